ifu_prefetch: RTL

Parametrised instruction-fetch unit with its own PC, a credit-limited request pipeline to instruction memory, and a DEPTH-entry instruction buffer feeding the decode unit (dfu). It sits between the pc/branch logic and dfu. Unlike the single-cycle pass-through fetch stage, it keeps up to DEPTH requests in flight, buffers returned instructions with their PCs, and applies backpressure from dfu. It also flushes cleanly on a redirect, discarding responses from stale requests.

---
 rtl/ifu_prefetch_pkg.sv | 14 +
 rtl/ifu_fifo.sv | 52 +++++
 rtl/ifu_prefetch.sv | 94 +++++++++
 3 files changed

// File: rtl/ifu_prefetch_pkg.sv
// Shared constants and helpers for the prefetching instruction-fetch unit.
// Holds the reset PC and instruction width used as the top-level defaults.
package ifu_prefetch_pkg;

  localparam logic [63:0]  RESET_VAL  = 64'h0000_0000_8000_0000;
  localparam int unsigned  INST_WIDTH = 32;
  localparam int unsigned  PC_STEP    = 4;

  // Bits needed to hold a count in 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous instruction buffer holding {pc, inst} entries for the decode unit.
// Flush wins over push and pop; head reads as zero while the buffer is empty.
module ifu_fifo
  import ifu_prefetch_pkg::*;
#(
  parameter int unsigned WIDTH = 96,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] head,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (do_pop && !do_push) count <= count - CNT_W'(1);
    end
  end

  // Storage needs no reset: head is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push && !flush && !rst) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction-fetch unit with its own PC, credit-limited memory requests and an
// instruction buffer to decode; redirects flush the buffer and drop stale responses.
module ifu_prefetch
  import ifu_prefetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 64,
  parameter int unsigned       INST_W   = INST_WIDTH,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_VAL)
) (
  input  logic              core_clk,
  input  logic              core_rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              ifu_memory_valid,
  output logic [ADDR_W-1:0] ifu_memory_addr,
  input  logic              memory_ifu_ready,
  input  logic              memory_ifu_valid,
  input  logic [INST_W-1:0] memory_ifu_data,
  output logic              ifu_dfu_valid,
  output logic [INST_W-1:0] ifu_dfu_inst,
  output logic [ADDR_W-1:0] ifu_dfu_pc,
  input  logic              dfu_ifu_ready,
  output logic              ifu_pc_pause
);

  localparam int unsigned CNT_W = cnt_width(DEPTH);
  localparam int unsigned ENT_W = ADDR_W + INST_W;

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] rsp_pc;
  logic [CNT_W-1:0]  inflight;
  logic [CNT_W-1:0]  drop_cnt;
  logic [CNT_W-1:0]  buf_count;
  logic [CNT_W:0]    credits_used;
  logic              req_fire;
  logic              rsp_keep;
  logic              pop;
  logic              buf_empty;
  logic [ENT_W-1:0]  head;

  // A request may issue only if every outstanding request still has a buffer slot.
  assign credits_used     = (CNT_W+1)'(buf_count) + (CNT_W+1)'(inflight);
  assign ifu_memory_valid = !core_rst && !redirect_valid &&
                            (credits_used < (CNT_W+1)'(DEPTH));
  assign ifu_memory_addr  = fetch_pc;
  assign ifu_pc_pause     = !ifu_memory_valid;

  assign req_fire = ifu_memory_valid && memory_ifu_ready;
  assign rsp_keep = memory_ifu_valid && (drop_cnt == '0) && !redirect_valid;
  assign pop      = ifu_dfu_valid && dfu_ifu_ready && !redirect_valid;

  // PC, in-flight and stale-response tracking.
  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      inflight <= '0;
      drop_cnt <= '0;
    end else begin
      inflight <= inflight + CNT_W'(req_fire) - CNT_W'(memory_ifu_valid);
      if (redirect_valid) begin
        fetch_pc <= redirect_pc;
        rsp_pc   <= redirect_pc;
        // Everything still outstanding after this cycle belongs to the old path.
        drop_cnt <= inflight - CNT_W'(memory_ifu_valid);
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
        if (rsp_keep) rsp_pc   <= rsp_pc + ADDR_W'(PC_STEP);
        if (memory_ifu_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - CNT_W'(1);
      end
    end
  end

  ifu_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (core_clk),
    .rst       (core_rst),
    .push      (rsp_keep),
    .push_data ({rsp_pc, memory_ifu_data}),
    .pop       (pop),
    .flush     (redirect_valid),
    .count     (buf_count),
    .head      (head),
    .empty     (buf_empty)
  );

  assign ifu_dfu_valid = !buf_empty;
  assign ifu_dfu_pc    = head[ENT_W-1 -: ADDR_W];
  assign ifu_dfu_inst  = head[INST_W-1:0];

endmodule
